// File: rtl/b02_sched_pkg.sv
// Shared types and the b02 recognizer next-state/output equations used by the
// multi-channel scheduler.
package b02_sched_pkg;

    typedef logic [2:0] b02_state_t;

    localparam b02_state_t RESET_STATE = 3'b000;
    localparam int         MAX_NCH     = 16;

    // Returns {u, next_state} for current state s and serial input bit x.
    function automatic logic [3:0] b02_next(input b02_state_t s, input logic x);
        logic s2, s1, s0;
        logic n2, n1, n0, u;
        {s2, s1, s0} = s;
        n0 = (x & (s != 3'b000)) | (s2 & (s1 ^ s0));
        n1 = (s2 & ~s1 & ~x) | (x & (s1 | (~s2 & ~s0)));
        n2 = (~s2 & ~x) | (~s1 & ~(s2 & s0) & (s0 | ~x));
        u  = s1 & ~s2 & ~x;
        return {u, n2, n1, n0};
    endfunction

endpackage

// File: rtl/b02_core_comb.sv
// Single combinational copy of the b02 recognizer core, time-shared by the scheduler.
module b02_core_comb
    import b02_sched_pkg::*;
(
    input  b02_state_t s,
    input  logic       x,
    output b02_state_t nxt,
    output logic       u
);

    assign {u, nxt} = b02_next(s, x);

endmodule

// File: rtl/b02_mux_scheduler.sv
// Round-robin scheduler multiplexing NCH bit streams onto one b02 core, with a
// per-channel state register and a one-deep result slot per channel.
module b02_mux_scheduler
    import b02_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NCH-1:0]     chan_clr,
    input  logic [NCH-1:0]     in_valid,
    input  logic [NCH-1:0]     in_bit,
    output logic [NCH-1:0]     in_ready,
    output logic [NCH-1:0]     out_valid,
    output logic [NCH-1:0]     out_u,
    output logic [3*NCH-1:0]   out_state,
    input  logic [NCH-1:0]     out_ready
);

    localparam int PW = $clog2(NCH);

    logic [NCH-1:0][2:0] st;
    logic [NCH-1:0][2:0] ost;
    logic [PW-1:0]       ptr;
    logic [NCH-1:0]      elig;
    logic [NCH-1:0]      grant;
    logic [PW-1:0]       gidx;
    logic                found;
    b02_state_t          core_nxt;
    logic                core_u;

    // A full slot only accepts a new bit if it is being drained this cycle.
    assign elig = in_valid & ~chan_clr & (~out_valid | out_ready) & {NCH{~reset}};

    always_comb begin
        int            sum;
        logic [PW-1:0] idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NCH) sum -= NCH;
            idx = PW'(sum);
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    assign in_ready  = grant;
    assign out_state = ost;

    b02_core_comb u_core (
        .s   (st[gidx]),
        .x   (in_bit[gidx]),
        .nxt (core_nxt),
        .u   (core_u)
    );

    always_ff @(posedge clock) begin
        if (reset)      ptr <= '0;
        else if (found) ptr <= (gidx == PW'(NCH-1)) ? '0 : gidx + 1'b1;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        always_ff @(posedge clock) begin
            if (reset || chan_clr[i]) begin
                st[i]        <= RESET_STATE;
                ost[i]       <= RESET_STATE;
                out_u[i]     <= 1'b0;
                out_valid[i] <= 1'b0;
            end else if (grant[i]) begin
                st[i]        <= core_nxt;
                ost[i]       <= core_nxt;
                out_u[i]     <= core_u;
                out_valid[i] <= 1'b1;
            end else if (out_ready[i]) begin
                out_valid[i] <= 1'b0;
            end
        end
    end

endmodule

// File: doc/b02_mux_scheduler.md
Name: b02_mux_scheduler

Overview:
- Time-shares one copy of the b02 recognizer's combinational next-state/output core among NCH independent serial bit streams.
- Holds a 3-bit state register per channel and arbitrates round-robin, one channel per cycle, with valid/ready handshakes on input and output.
- Each channel's output is the Mealy output u plus its updated state.
- Sits between bit-serial producers and the consumers of the recognizer flag.

Parameters:
- NCH, 4, number of channels; legal range 2..16.
- PW, $clog2(NCH), width of the round-robin pointer; derived, not overridable.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- chan_clr  in  NCH  per-channel synchronous clear of that channel's state and result slot.
- in_valid  in  NCH  channel i presents a bit.
- in_bit  in  NCH  serial input bit x for channel i.
- in_ready  out  NCH  channel i's bit is consumed this cycle (grant); combinational.
- out_valid  out  NCH  channel i's result slot is full.
- out_u  out  NCH  recognizer output u for channel i's last consumed bit.
- out_state  out  3*NCH  channel i's state after the last consumed bit; bits [3i+2:3i].
- out_ready  in  NCH  consumer of channel i takes the result.

Behaviour:
- Shared core, with s = {s2,s1,s0} the current state and x the input bit:
  - n0 = x&(s!=0) | s2&(s1^s0)
  - n1 = s2&~s1&~x | x&(s1 | ~s2&~s0)
  - n2 = ~s2&~x | ~s1&~(s2&s0)&(s0|~x)
  - u = s1&~s2&~x
  - next state = {n2,n1,n0}.
- Reset: all state registers = 3'b000, out_valid = 0, out_u = 0, out_state = 0, pointer = 0. in_ready = 0 while reset is high.
- Eligibility: channel i is eligible when in_valid[i] & ~chan_clr[i] & (~out_valid[i] | out_ready[i]).
- Grant: the first eligible channel scanning ptr, ptr+1, … with wrap at NCH-1 → 0. At most one grant per cycle. in_ready is one-hot or zero.
- On a grant to channel g:
  - Core evaluated on state[g] and in_bit[g].
  - Next edge: state[g] <= next, out_state[g] <= next, out_u[g] <= u, out_valid[g] <= 1, ptr <= g+1 (mod NCH).
  - Latency is one cycle from acceptance to out_valid.
- No grant: ptr unchanged.
- Output handshake:
  - out_valid[i] & out_ready[i] with no new grant to i → out_valid[i] <= 0.
  - Pop and grant on the same channel in the same cycle → slot refilled and out_valid stays 1 (full throughput per channel).
  - Holding out_ready low stalls only that channel; other channels proceed.
- out_u and out_state hold their values while out_valid is low; they change only on a grant or a clear.
- chan_clr[i]: next edge state[i] = 0, out_valid[i] = 0, out_u[i] = 0, out_state[i] = 0.
  - Clear has priority over grant and pop, and blocks the grant in that cycle.
- reset mid-operation: any in-flight result is discarded and no grant is issued. The first grant after reset goes to the lowest eligible index.
- No state is kept per un-granted request: a producer holds in_valid and in_bit until it sees in_ready.

Decomposition:
- Package b02_sched_pkg:
  - state typedef (logic [2:0]); RESET_STATE = 3'b000.
  - MAX_NCH = 16.
  - function b02_next(s, x) returning {u, next}.
- Sub-module b02_core_comb: pure combinational core implementing the equations above, instantiated once.
- Round-robin arbiter kept inline; a rotate, priority-encode, unrotate structure is acceptable.

Test Plan:
- Reset, then ch0 only, in_bit=1 → cycle+1: out_valid[0]=1, out_u[0]=0, out_state[0]=3'b010. Next bit 0 → out_u[0]=1, out_state[0]=3'b100.
- Reset, ch0 in_bit=0 → out_state[0]=3'b100, out_u[0]=0. Other channels' out_valid stay 0.
- All four channels in_valid=1 continuously, out_ready=all 1 → in_ready sequence 0001, 0010, 0100, 1000, 0001. Each channel sees one result every 4 cycles.
- ch1 has out_valid=1 with out_ready[1]=0, all channels valid → ch1 never granted, in_ready[1]=0, rotation is 0, 2, 3. Raising out_ready[1] → ch1 granted on its next turn.
- chan_clr[2] asserted in the same cycle as its grant would occur → no grant to 2. Next cycle state[2]=0, out_valid[2]=0, and ptr advances to the next eligible channel.
- reset asserted while out_valid=1111 → next edge all outputs 0 and ptr=0. First grant goes to lowest eligible index; its state restarts from 3'b000.
